// File: rtl/slc3_control_pkg.sv
// Shared types for the SLC-3 controller: opcode, datapath mux encodings,
// controller state names and the bundled control word that the FSM
// registers and fans out to the datapath.
package lc3b_types;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_PSE  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        PC_BUS  = 2'b00,
        PC_INC  = 2'b01,
        PC_ADDR = 2'b10
    } pcmux_e;

    typedef enum logic [1:0] {
        A2_ZERO  = 2'b00,
        A2_OFF6  = 2'b01,
        A2_OFF9  = 2'b10,
        A2_OFF11 = 2'b11
    } addr2_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_AND   = 2'b01,
        ALU_NOT   = 2'b10,
        ALU_PASSA = 2'b11
    } aluk_e;

    typedef enum logic [4:0] {
        S_HALT,
        S_18,       // MAR <- PC, PC <- PC+1
        S_33,       // instruction read
        S_35,       // IR <- MDR
        S_32,       // BEN load + decode
        S_ADD,
        S_AND,
        S_NOT,
        S_BR,       // taken branch only
        S_JMP,
        S_JSR_R7,   // R7 <- PC
        S_JSR_OFF,  // PC <- PC + off11
        S_JSR_REG,  // PC <- SR1
        S_LDR_MAR,
        S_LDR_RD,
        S_LDR_WB,
        S_STR_MAR,
        S_STR_MDR,
        S_STR_WR,
        S_P1,       // paused, waiting for Continue high
        S_P2        // waiting for Continue to drop
    } state_e;

    typedef struct packed {
        logic   load_ir;
        logic   load_pc;
        logic   load_mar;
        logic   load_mdr;
        logic   load_reg;
        logic   load_ben;
        logic   load_cc;
        logic   gate_pc;
        logic   gate_mdr;
        logic   gate_alu;
        logic   gate_marmux;
        pcmux_e pc_sel;
        logic   addr1_sel;
        addr2_e addr2_sel;
        logic   sr1_sel;
        logic   dr_sel;
        aluk_e  aluk;
        logic   mio_en;
        logic   mem_ce_n;
        logic   mem_ub_n;
        logic   mem_lb_n;
        logic   mem_oe_n;
        logic   mem_we_n;
        logic   halted;
    } ctrl_t;

    // Nothing loaded, nothing on the bus, SRAM deselected.
    localparam ctrl_t CTRL_IDLE = '{
        pc_sel:    PC_BUS,
        addr2_sel: A2_ZERO,
        aluk:      ALU_ADD,
        mem_ce_n:  1'b1,
        mem_ub_n:  1'b1,
        mem_lb_n:  1'b1,
        mem_oe_n:  1'b1,
        mem_we_n:  1'b1,
        default:   1'b0
    };

endpackage

// File: rtl/slc3_control_mem_timer.sv
// mem_strobe_timer: down-counter that holds an SRAM strobe for MEM_CYCLES
// cycles.
//   clk        rising-edge clock
//   rst        synchronous active-high clear
//   start      pulse on the cycle the FSM enters a memory state
//   done       counter is at zero this cycle (last strobe cycle)
//   done_next  counter will be at zero next cycle; lets the FSM register
//              the last-cycle outputs one cycle early
module mem_strobe_timer #(
    parameter int MEM_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done,
    output logic done_next
);

    localparam int CW = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(MEM_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign done      = (cnt_q == '0);
    assign done_next = (cnt_d == '0);

endmodule

// File: rtl/slc3_control.sv
// slc3_control: fetch/decode/execute sequencer for the SLC-3 datapath.
//   Clk, Reset (sync, active high), Run (leave HALT), Continue (leave PAUSE)
//   opcode = IR[15:12], ir_5, ir_11, ben from the datapath
//   load_*, gate_*, mux selects, aluk, mio_en: datapath controls
//   mem_*_n: active-low SRAM strobes; halted: FSM sits in S_HALT
// Outputs are registered: the control word is decoded from the next state
// and latched together with it, so each output is a clean flop that still
// reflects the current state.
module slc3_control
    import lc3b_types::*;
#(
    parameter int MEM_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] opcode,
    input  logic       ir_5,
    input  logic       ir_11,
    input  logic       ben,
    output logic       load_ir,
    output logic       load_pc,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_reg,
    output logic       load_ben,
    output logic       load_cc,
    output logic       gate_pc,
    output logic       gate_mdr,
    output logic       gate_alu,
    output logic       gate_marmux,
    output logic [1:0] pc_sel,
    output logic       addr1_sel,
    output logic [1:0] addr2_sel,
    output logic       sr1_sel,
    output logic       dr_sel,
    output logic [1:0] aluk,
    output logic       mio_en,
    output logic       mem_ce_n,
    output logic       mem_ub_n,
    output logic       mem_lb_n,
    output logic       mem_oe_n,
    output logic       mem_we_n,
    output logic       halted
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   mem_start, mem_done, mem_last_d;
    op_e    op;

    // The SR2 mux in the datapath takes IR[5] directly; the controller only
    // has to issue the same ALU step for both register and immediate forms.
    logic unused_ir_5;
    assign unused_ir_5 = ir_5;

    assign op = op_e'(opcode);

    function automatic logic is_mem(state_e s);
        return s inside {S_33, S_LDR_RD, S_STR_WR};
    endfunction

    // Every memory state is entered from a non-memory state.
    assign mem_start = is_mem(state_d) && !is_mem(state_q);

    mem_strobe_timer #(.MEM_CYCLES(MEM_CYCLES)) u_mem_timer (
        .clk       (Clk),
        .rst       (Reset),
        .start     (mem_start),
        .done      (mem_done),
        .done_next (mem_last_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALT:    if (Run) state_d = S_18;
            S_18:      state_d = S_33;
            S_33:      if (mem_done) state_d = S_35;
            S_35:      state_d = S_32;
            S_32: begin
                case (op)
                    OP_ADD:  state_d = S_ADD;
                    OP_AND:  state_d = S_AND;
                    OP_NOT:  state_d = S_NOT;
                    OP_BR:   state_d = ben ? S_BR : S_18;
                    OP_JMP:  state_d = S_JMP;
                    OP_JSR:  state_d = S_JSR_R7;
                    OP_LDR:  state_d = S_LDR_MAR;
                    OP_STR:  state_d = S_STR_MAR;
                    OP_PSE:  state_d = S_P1;
                    default: state_d = S_18;
                endcase
            end
            S_JSR_R7:  state_d = ir_11 ? S_JSR_OFF : S_JSR_REG;
            S_LDR_MAR: state_d = S_LDR_RD;
            S_LDR_RD:  if (mem_done) state_d = S_LDR_WB;
            S_STR_MAR: state_d = S_STR_MDR;
            S_STR_MDR: state_d = S_STR_WR;
            S_STR_WR:  if (mem_done) state_d = S_18;
            // Two-phase handshake so a held Continue resumes only once.
            S_P1:      if (Continue) state_d = S_P2;
            S_P2:      if (!Continue) state_d = S_18;
            S_ADD, S_AND, S_NOT, S_BR, S_JMP, S_JSR_OFF, S_JSR_REG, S_LDR_WB:
                       state_d = S_18;
            default:   state_d = S_HALT;
        endcase
    end

    // last: the memory counter is on its final strobe cycle in state s.
    function automatic ctrl_t decode(state_e s, logic last);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            S_HALT: c.halted = 1'b1;
            S_18: begin
                c.gate_pc  = 1'b1;
                c.load_mar = 1'b1;
                c.load_pc  = 1'b1;
                c.pc_sel   = PC_INC;
            end
            S_33, S_LDR_RD: begin
                c.mem_ce_n = 1'b0;
                c.mem_oe_n = 1'b0;
                c.mem_ub_n = 1'b0;
                c.mem_lb_n = 1'b0;
                c.mio_en   = 1'b1;
                c.load_mdr = last;
            end
            S_35: begin
                c.gate_mdr = 1'b1;
                c.load_ir  = 1'b1;
            end
            S_32: c.load_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                c.gate_alu = 1'b1;
                c.load_reg = 1'b1;
                c.load_cc  = 1'b1;
                c.aluk     = (s == S_ADD) ? ALU_ADD : (s == S_AND) ? ALU_AND : ALU_NOT;
            end
            S_BR, S_JSR_OFF: begin
                c.load_pc   = 1'b1;
                c.pc_sel    = PC_ADDR;
                c.addr1_sel = 1'b0;
                c.addr2_sel = (s == S_BR) ? A2_OFF9 : A2_OFF11;
            end
            S_JMP, S_JSR_REG: begin
                c.load_pc   = 1'b1;
                c.pc_sel    = PC_ADDR;
                c.addr1_sel = 1'b1;
                c.addr2_sel = A2_ZERO;
            end
            S_JSR_R7: begin
                c.gate_pc  = 1'b1;
                c.dr_sel   = 1'b1;
                c.load_reg = 1'b1;
            end
            S_LDR_MAR, S_STR_MAR: begin
                c.gate_marmux = 1'b1;
                c.load_mar    = 1'b1;
                c.addr1_sel   = 1'b1;
                c.addr2_sel   = A2_OFF6;
            end
            S_LDR_WB: begin
                c.gate_mdr = 1'b1;
                c.load_reg = 1'b1;
                c.load_cc  = 1'b1;
            end
            S_STR_MDR: begin
                c.aluk     = ALU_PASSA;
                c.gate_alu = 1'b1;
                c.mio_en   = 1'b0;
                c.load_mdr = 1'b1;
            end
            S_STR_WR: begin
                c.mem_ce_n = 1'b0;
                c.mem_we_n = 1'b0;
                c.mem_ub_n = 1'b0;
                c.mem_lb_n = 1'b0;
            end
            default: ;
        endcase
        return c;
    endfunction

    assign ctrl_d = decode(state_d, mem_last_d);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_HALT;
            ctrl_q  <= decode(S_HALT, 1'b0);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign load_ir     = ctrl_q.load_ir;
    assign load_pc     = ctrl_q.load_pc;
    assign load_mar    = ctrl_q.load_mar;
    assign load_mdr    = ctrl_q.load_mdr;
    assign load_reg    = ctrl_q.load_reg;
    assign load_ben    = ctrl_q.load_ben;
    assign load_cc     = ctrl_q.load_cc;
    assign gate_pc     = ctrl_q.gate_pc;
    assign gate_mdr    = ctrl_q.gate_mdr;
    assign gate_alu    = ctrl_q.gate_alu;
    assign gate_marmux = ctrl_q.gate_marmux;
    assign pc_sel      = ctrl_q.pc_sel;
    assign addr1_sel   = ctrl_q.addr1_sel;
    assign addr2_sel   = ctrl_q.addr2_sel;
    assign sr1_sel     = ctrl_q.sr1_sel;
    assign dr_sel      = ctrl_q.dr_sel;
    assign aluk        = ctrl_q.aluk;
    assign mio_en      = ctrl_q.mio_en;
    assign mem_ce_n    = ctrl_q.mem_ce_n;
    assign mem_ub_n    = ctrl_q.mem_ub_n;
    assign mem_lb_n    = ctrl_q.mem_lb_n;
    assign mem_oe_n    = ctrl_q.mem_oe_n;
    assign mem_we_n    = ctrl_q.mem_we_n;
    assign halted      = ctrl_q.halted;

    // Single bus driver, and never read and write the SRAM together.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            assert ($onehot0({gate_pc, gate_mdr, gate_alu, gate_marmux}));
            assert (mem_oe_n || mem_we_n);
        end
    end

endmodule

// File: tb/tb_slc3_control.sv
// Instruction-level model: each instruction expands into its expected
// per-cycle control words (fetch, then the execute micro-steps), each paired
// with the inputs to drive that cycle. One loop drives and compares.
module tb_slc3_control;

    localparam int MC = 2;

    logic       Clk = 1'b0, Reset = 1'b1, Run = 1'b0, Continue = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       ir_5 = 1'b0, ir_11 = 1'b0, ben = 1'b0;
    logic load_ir, load_pc, load_mar, load_mdr, load_reg, load_ben, load_cc;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pc_sel, addr2_sel, aluk;
    logic addr1_sel, sr1_sel, dr_sel, mio_en;
    logic mem_ce_n, mem_ub_n, mem_lb_n, mem_oe_n, mem_we_n, halted;

    slc3_control #(.MEM_CYCLES(MC)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .opcode(opcode), .ir_5(ir_5), .ir_11(ir_11), .ben(ben),
        .load_ir(load_ir), .load_pc(load_pc), .load_mar(load_mar), .load_mdr(load_mdr),
        .load_reg(load_reg), .load_ben(load_ben), .load_cc(load_cc),
        .gate_pc(gate_pc), .gate_mdr(gate_mdr), .gate_alu(gate_alu), .gate_marmux(gate_marmux),
        .pc_sel(pc_sel), .addr1_sel(addr1_sel), .addr2_sel(addr2_sel),
        .sr1_sel(sr1_sel), .dr_sel(dr_sel), .aluk(aluk), .mio_en(mio_en),
        .mem_ce_n(mem_ce_n), .mem_ub_n(mem_ub_n), .mem_lb_n(mem_lb_n),
        .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .halted(halted)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic ld_ir, ld_pc, ld_mar, ld_mdr, ld_reg, ld_ben, ld_cc;
        logic g_pc, g_mdr, g_alu, g_marmux;
        logic [1:0] pc_sel;
        logic       addr1;
        logic [1:0] addr2;
        logic       sr1, dr;
        logic [1:0] aluk;
        logic       mio;
        logic ce_n, ub_n, lb_n, oe_n, we_n;
        logic halted;
    } cw_t;

    cw_t got;
    assign got = {load_ir, load_pc, load_mar, load_mdr, load_reg, load_ben, load_cc,
                  gate_pc, gate_mdr, gate_alu, gate_marmux, pc_sel, addr1_sel, addr2_sel,
                  sr1_sel, dr_sel, aluk, mio_en,
                  mem_ce_n, mem_ub_n, mem_lb_n, mem_oe_n, mem_we_n, halted};

    typedef struct {
        bit rst, run, cont, i5, i11, bn, chk;
        bit [3:0] op;
        cw_t exp;
        string tag;
    } ent_t;

    ent_t q[$];
    int errors = 0, checks = 0, cyc = 0;
    bit [3:0] cur_op;
    bit cur_ben, cur_i11, cur_i5, noise;
    int n_we, n_oe, n_ldpc, n_ldir, n_ldmdr, n_ldreg, n_ldmar, n_br, n_ovl, n_idle, n_gates;

    // ---- control-word vocabulary ----
    function automatic cw_t idle();
        cw_t c = '0;
        c.ce_n = 1; c.ub_n = 1; c.lb_n = 1; c.oe_n = 1; c.we_n = 1;
        return c;
    endfunction
    function automatic cw_t halt_cw();
        cw_t c = idle(); c.halted = 1; return c;
    endfunction
    function automatic cw_t mem_read(bit last);
        cw_t c = idle();
        c.ce_n = 0; c.oe_n = 0; c.ub_n = 0; c.lb_n = 0; c.mio = 1; c.ld_mdr = last;
        return c;
    endfunction
    function automatic cw_t mem_write();
        cw_t c = idle();
        c.ce_n = 0; c.we_n = 0; c.ub_n = 0; c.lb_n = 0;
        return c;
    endfunction
    function automatic cw_t alu_wr(bit [1:0] k);
        cw_t c = idle();
        c.g_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.aluk = k;
        return c;
    endfunction
    function automatic cw_t pc_addr(bit a1, bit [1:0] a2);
        cw_t c = idle();
        c.ld_pc = 1; c.pc_sel = 2'b10; c.addr1 = a1; c.addr2 = a2;
        return c;
    endfunction
    function automatic cw_t mar_off6();
        cw_t c = idle();
        c.g_marmux = 1; c.ld_mar = 1; c.addr1 = 1; c.addr2 = 2'b01;
        return c;
    endfunction

    // cont < 0: Continue is don't-care noise (or 0 in directed sections)
    function automatic void push(cw_t e, string tag, int cont = -1);
        ent_t n;
        n.rst = 0; n.chk = 1;
        n.run = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        n.cont = (cont >= 0) ? (cont != 0) : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
        n.op = cur_op; n.bn = cur_ben; n.i11 = cur_i11; n.i5 = cur_i5;
        n.exp = e; n.tag = tag;
        q.push_back(n);
    endfunction

    // Pause: w0 cycles with Continue low, h cycles high, then one low cycle
    // after which the next fetch starts.
    function automatic void push_instr(bit [3:0] op, bit bn, bit i11, int w0 = 0, int h = 1);
        cw_t c;
        cur_op = op; cur_ben = bn; cur_i11 = i11;
        cur_i5 = noise ? 1'($urandom_range(0, 1)) : op[1];
        c = idle(); c.g_pc = 1; c.ld_mar = 1; c.ld_pc = 1; c.pc_sel = 2'b01; push(c, "fetch_mar");
        for (int i = 0; i < MC; i++) push(mem_read(i == MC - 1), "fetch_read");
        c = idle(); c.g_mdr = 1; c.ld_ir = 1; push(c, "fetch_ir");
        c = idle(); c.ld_ben = 1; push(c, "decode");
        case (op)
            4'b0001: push(alu_wr(2'b00), "add");
            4'b0101: push(alu_wr(2'b01), "and");
            4'b1001: push(alu_wr(2'b10), "not");
            4'b0000: if (bn) push(pc_addr(1'b0, 2'b10), "br_taken");
            4'b1100: push(pc_addr(1'b1, 2'b00), "jmp");
            4'b0100: begin
                c = idle(); c.g_pc = 1; c.dr = 1; c.ld_reg = 1; push(c, "jsr_r7");
                push(i11 ? pc_addr(1'b0, 2'b11) : pc_addr(1'b1, 2'b00), "jsr_pc");
            end
            4'b0110: begin
                push(mar_off6(), "ldr_mar");
                for (int i = 0; i < MC; i++) push(mem_read(i == MC - 1), "ldr_read");
                c = idle(); c.g_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; push(c, "ldr_wb");
            end
            4'b0111: begin
                push(mar_off6(), "str_mar");
                c = idle(); c.aluk = 2'b11; c.g_alu = 1; c.ld_mdr = 1; push(c, "str_mdr");
                for (int i = 0; i < MC; i++) push(mem_write(), "str_write");
            end
            4'b1101: begin
                for (int i = 0; i < w0; i++) push(idle(), "pause_wait", 0);
                for (int i = 0; i < h; i++)  push(idle(), "pause_held", 1);
                push(idle(), "pause_release", 0);
            end
            default: ;
        endcase
    endfunction

    function automatic void push_halts(int n, bit run_last);
        for (int i = 0; i < n; i++) push(halt_cw(), "halt", 0);
        q[$].run = run_last;
        q[$].cont = 0;
    endfunction

    task automatic clr_tally();
        n_we = 0; n_oe = 0; n_ldpc = 0; n_ldir = 0; n_ldmdr = 0; n_ldreg = 0;
        n_ldmar = 0; n_br = 0; n_ovl = 0; n_idle = 0; n_gates = 0;
    endtask

    task automatic play();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge Clk); #1;
            Reset = e.rst; Run = e.run; Continue = e.cont; opcode = e.op;
            ben = e.bn; ir_11 = e.i11; ir_5 = e.i5;
            @(negedge Clk);
            cyc++;
            if (e.chk) begin
                checks++;
                if (got !== e.exp) begin
                    errors++;
                    $display("FAIL %s cycle=%0d got=%h want=%h", e.tag, cyc, got, e.exp);
                end
            end
            n_we    += int'(!mem_we_n);
            n_oe    += int'(!mem_oe_n);
            n_ovl   += int'(!mem_we_n && !mem_oe_n);
            n_ldpc  += int'(load_pc);
            n_ldir  += int'(load_ir);
            n_ldmdr += int'(load_mdr);
            n_ldreg += int'(load_reg);
            n_ldmar += int'(load_mar);
            n_br    += int'(load_pc && pc_sel == 2'b10);
            n_idle  += int'(got == idle());
            n_gates += int'(!$onehot0({gate_pc, gate_mdr, gate_alu, gate_marmux}));
        end
    endtask

    task automatic lit(string name, int act, int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        noise = 0; cur_op = 0; cur_ben = 0; cur_i11 = 0; cur_i5 = 0;

        // reset state
        push(idle(), "reset"); q[$].rst = 1; q[$].chk = 0;
        push_halts(3, 1'b0);
        clr_tally(); play();
        lit("reset_halted", int'(halted), 1);
        lit("reset_oe_n", int'(mem_oe_n), 1);

        // Run from HALT, BR not taken: only the fetch load_pc
        push_halts(1, 1'b1);
        push_instr(4'b0000, 1'b0, 1'b0);
        clr_tally(); play();
        lit("brnt_load_pc", n_ldpc, 1);
        lit("brnt_load_mar", n_ldmar, 1);
        lit("brnt_load_mdr", n_ldmdr, 1);
        lit("brnt_oe_cycles", n_oe, 2);
        lit("brnt_load_ir", n_ldir, 1);

        // BR taken
        push_instr(4'b0000, 1'b1, 1'b0);
        clr_tally(); play();
        lit("brt_load_pc", n_ldpc, 2);
        lit("brt_addr_pc", n_br, 1);

        // STR write strobe length
        push_instr(4'b0111, 1'b0, 1'b0);
        clr_tally(); play();
        lit("str_we_cycles", n_we, 2);
        lit("str_overlap", n_ovl, 0);

        // LDR: two reads, one register write
        push_instr(4'b0110, 1'b0, 1'b0);
        clr_tally(); play();
        lit("ldr_oe_cycles", n_oe, 4);
        lit("ldr_load_mdr", n_ldmdr, 2);
        lit("ldr_load_reg", n_ldreg, 1);

        // ALU ops, jumps, unknown opcodes
        push_instr(4'b0001, 1'b0, 1'b0);
        push_instr(4'b0101, 1'b1, 1'b1);
        push_instr(4'b1001, 1'b0, 1'b0);
        push_instr(4'b1100, 1'b0, 1'b0);
        push_instr(4'b0100, 1'b0, 1'b1);
        push_instr(4'b0100, 1'b0, 1'b0);
        push_instr(4'b1111, 1'b1, 1'b0);
        push_instr(4'b0010, 1'b0, 1'b1);
        clr_tally(); play();
        lit("mix_load_reg", n_ldreg, 5);
        lit("mix_load_ir", n_ldir, 8);

        // PAUSE, Continue held 5 cycles, then one NOP, then reset
        push_instr(4'b1101, 1'b0, 1'b0, 0, 5);
        push_instr(4'b1110, 1'b0, 1'b0);
        q[$].rst = 1;
        push_halts(2, 1'b0);
        clr_tally(); play();
        lit("pause_fetches", n_ldir, 2);
        lit("pause_idle_cycles", n_idle, 6);

        // reset in the first read cycle of a fetch
        push_halts(1, 1'b1);
        push_instr(4'b0001, 1'b0, 1'b0);
        while (q.size() > 3) void'(q.pop_back());   // halt-run, S18, first read
        q[$].rst = 1;
        push_halts(2, 1'b0);
        clr_tally(); play();
        lit("midread_halted", int'(halted), 1);
        lit("midread_oe_n", int'(mem_oe_n), 1);
        lit("midread_loads", int'({load_ir, load_pc, load_mar, load_mdr, load_reg, load_ben, load_cc}), 0);
        lit("midread_load_mdr", n_ldmdr, 0);

        // reset in the first write cycle of a store: no further write cycle
        push_halts(1, 1'b1);
        push_instr(4'b0111, 1'b0, 1'b0);
        void'(q.pop_back());
        q[$].rst = 1;
        push_halts(2, 1'b0);
        clr_tally(); play();
        lit("midwrite_we_cycles", n_we, 1);
        lit("midwrite_halted", int'(halted), 1);

        // random instruction stream with Run/Continue noise
        push_halts(1, 1'b1);
        play();
        noise = 1;
        clr_tally();
        while (cyc < 9500) begin
            push_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
            play();
        end
        lit("rand_overlap", n_ovl, 0);
        lit("rand_multi_gate", n_gates, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
